// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud-rate generator with oversample, bit and mid-bit ticks
module baud_gen_frac #(
    parameter int FREQ_W  = 12,
    parameter int LIMIT_W = 16,
    parameter int OVS     = 16,
    parameter int OVS_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               phase_clr,
    input  logic               cfg_load,
    input  logic [FREQ_W-1:0]  cfg_freq,
    input  logic [LIMIT_W-1:0] cfg_limit,
    output logic               cfg_pending,
    output logic               cfg_err,
    output logic               ce_ovs,
    output logic               ce_bit,
    output logic               ce_mid
);

    // One spare bit keeps acc < act_limit + act_freq representable.
    localparam int ACC_W = LIMIT_W + 1;

    logic [FREQ_W-1:0]  act_freq;
    logic [LIMIT_W-1:0] act_limit;
    logic [FREQ_W-1:0]  shadow_freq;
    logic [LIMIT_W-1:0] shadow_limit;
    logic [ACC_W-1:0]   acc;
    logic [OVS_W-1:0]   sub;

    logic [ACC_W-1:0]   limit_ext;
    logic [ACC_W-1:0]   freq_ext;
    logic               run;
    logic               tick;
    logic               bit_hit;
    logic               mid_hit;
    logic               apply;
    logic               cfg_ok;

    // Tick decision, bit-boundary detection and config apply point.
    always_comb begin
        limit_ext = {1'b0, act_limit};
        freq_ext  = ACC_W'(act_freq);
        run       = enable && !phase_clr;
        // An unconfigured generator (act_freq == 0) must stay silent.
        tick      = run && (act_freq != '0) && (acc >= limit_ext);
        bit_hit   = tick && (sub == OVS_W'(OVS - 1));
        mid_hit   = tick && (sub == OVS_W'(OVS / 2 - 1));
        apply     = cfg_pending && (bit_hit || !enable || phase_clr || (act_freq == '0));
        cfg_ok    = (cfg_freq != '0) && (cfg_limit != '0);
    end

    // Accumulator, sub-counter, registered ticks and shadowed configuration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_freq     <= '0;
            act_limit    <= '0;
            shadow_freq  <= '0;
            shadow_limit <= '0;
            acc          <= '0;
            sub          <= '0;
            ce_ovs       <= 1'b0;
            ce_bit       <= 1'b0;
            ce_mid       <= 1'b0;
            cfg_pending  <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            ce_ovs <= tick;
            ce_bit <= bit_hit;
            ce_mid <= mid_hit;

            if (!run) begin
                acc <= '0;
                sub <= '0;
            end else if (tick) begin
                acc <= acc - limit_ext;
                sub <= sub + 1'b1;
            end else begin
                acc <= acc + freq_ext;
            end

            // Apply reads the old shadow even if a new load lands this cycle.
            if (apply) begin
                act_freq  <= shadow_freq;
                act_limit <= shadow_limit;
                acc       <= '0;
                sub       <= '0;
            end

            if (cfg_load && cfg_ok) begin
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end

            if (cfg_load) begin
                if (cfg_ok) begin
                    shadow_freq  <= cfg_freq;
                    shadow_limit <= cfg_limit;
                    cfg_err      <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - scoreboard bench for baud_gen_frac
module tb_baud_gen_frac;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        phase_clr;
    logic        cfg_load;
    logic [11:0] cfg_freq;
    logic [15:0] cfg_limit;
    logic        cfg_pending;
    logic        cfg_err;
    logic        ce_ovs;
    logic        ce_bit;
    logic        ce_mid;

    baud_gen_frac #(
        .FREQ_W (12),
        .LIMIT_W(16),
        .OVS    (16),
        .OVS_W  (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .phase_clr  (phase_clr),
        .cfg_load   (cfg_load),
        .cfg_freq   (cfg_freq),
        .cfg_limit  (cfg_limit),
        .cfg_pending(cfg_pending),
        .cfg_err    (cfg_err),
        .ce_ovs     (ce_ovs),
        .ce_bit     (ce_bit),
        .ce_mid     (ce_mid)
    );

    typedef struct {
        int cyc;
        bit eb;
        bit em;
    } exp_t;

    exp_t exp_q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   ovs_count = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle stamp: value k seen after the k-th rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Evenly spaced ticks after an apply/restart at cycle base; sub starts at 0.
    task automatic push_periodic(input int base, input int per, input int n);
        for (int j = 1; j <= n; j++) begin
            exp_t e;
            e.cyc = base + per * j;
            e.eb  = ((j - 1) % 16) == 15;
            e.em  = ((j - 1) % 16) == 7;
            exp_q.push_back(e);
        end
    endtask

    // freq=2/limit=3 from acc=0: ticks at offsets 3 and 5 in every 5-clock frame.
    task automatic push_frac(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.cyc = base + 5 * (k / 2) + (((k % 2) == 0) ? 3 : 5);
            e.eb  = (k % 16) == 15;
            e.em  = (k % 16) == 7;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every ce_ovs pulse is matched against the next expected tick.
    always @(negedge clock) begin
        if (ce_ovs) begin
            ovs_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick actual=cycle %0d required=no tick", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.eb != ce_bit || e.em != ce_mid) begin
                    errors++;
                    $display("FAIL tick actual=cyc %0d bit %0b mid %0b required=cyc %0d bit %0b mid %0b",
                             cyc, ce_bit, ce_mid, e.cyc, e.eb, e.em);
                end
            end
        end else if (ce_bit || ce_mid) begin
            checks++;
            errors++;
            $display("FAIL stray_tick actual=bit %0b mid %0b required=0 0 (cycle %0d)", ce_bit, ce_mid, cyc);
        end
    end

    initial begin
        int a, b, c, d, r, e, cnt0;
        reset     = 1'b1;
        enable    = 1'b0;
        phase_clr = 1'b0;
        cfg_load  = 1'b0;
        cfg_freq  = '0;
        cfg_limit = '0;

        wait_until(3);
        check("reset_ce_ovs", ce_ovs, 0);
        check("reset_ce_bit", ce_bit, 0);
        check("reset_ce_mid", ce_mid, 0);
        check("reset_pending", cfg_pending, 0);
        check("reset_err", cfg_err, 0);
        reset = 1'b0;

        // freq=1/limit=3: accepted at edge 6, applied at edge 7 (act_freq==0).
        wait_until(5);
        cfg_load = 1'b1; cfg_freq = 12'd1; cfg_limit = 16'd3; enable = 1'b1;
        a = 7;
        push_periodic(a, 4, 48);
        wait_until(6);
        cfg_load = 1'b0;
        check("load1_pending", cfg_pending, 1);
        wait_until(7);
        check("load1_applied", cfg_pending, 0);

        // Mid-bit reconfig to freq=1/limit=1, applied on the 48th tick's ce_bit.
        wait_until(a + 162);
        cfg_load = 1'b1; cfg_freq = 12'd1; cfg_limit = 16'd1;
        b = a + 192;
        push_periodic(b, 2, 32);
        wait_until(a + 163);
        cfg_load = 1'b0;
        check("reconf_pending", cfg_pending, 1);
        wait_until(a + 191);
        check("reconf_hold", cfg_pending, 1);
        wait_until(b);
        check("reconf_applied", cfg_pending, 0);

        // Fractional freq=2/limit=3, applied at the next ce_bit.
        wait_until(b + 40);
        cfg_load = 1'b1; cfg_freq = 12'd2; cfg_limit = 16'd3;
        c = b + 64;
        push_frac(c, 208);
        wait_until(b + 41);
        cfg_load = 1'b0;
        wait_until(c);
        check("frac_applied", cfg_pending, 0);
        wait_until(c + 1);
        cnt0 = ovs_count;

        // Rejected load leaves timing and pending alone.
        wait_until(c + 100);
        cfg_load = 1'b1; cfg_freq = 12'd0; cfg_limit = 16'd5;
        wait_until(c + 101);
        cfg_load = 1'b0;
        check("bad_err", cfg_err, 1);
        check("bad_pending", cfg_pending, 0);

        wait_until(c + 490);
        cfg_load = 1'b1; cfg_freq = 12'd1; cfg_limit = 16'd3;
        d = c + 520;
        push_periodic(d, 4, 5);
        wait_until(c + 491);
        cfg_load = 1'b0;
        check("good_err_clear", cfg_err, 0);
        check("good_pending", cfg_pending, 1);
        wait_until(c + 501);
        check("frac_500_count", ovs_count - cnt0, 200);
        wait_until(d);
        check("good_applied", cfg_pending, 0);

        // phase_clr for three edges mid-bit.
        wait_until(d + 21);
        phase_clr = 1'b1;
        r = d + 24;
        push_periodic(r, 4, 20);
        wait_until(d + 24);
        phase_clr = 1'b0;

        // enable low for ten edges, starting on a would-be tick.
        wait_until(r + 83);
        enable = 1'b0;
        wait_until(r + 84);
        check("disable_no_tick", ce_ovs, 0);
        wait_until(r + 93);
        enable = 1'b1;
        e = r + 93;
        push_periodic(e, 4, 21);

        // Pending config, then async reset while a tick is showing.
        wait_until(e + 66);
        cfg_load = 1'b1; cfg_freq = 12'd1; cfg_limit = 16'd1;
        wait_until(e + 67);
        cfg_load = 1'b0;
        check("pre_reset_pending", cfg_pending, 1);
        wait_until(e + 84);
        #5;
        reset = 1'b1;
        #1;
        check("async_reset_ovs", ce_ovs, 0);
        check("async_reset_pending", cfg_pending, 0);
        wait_until(e + 88);
        reset = 1'b0;
        wait_until(e + 89);
        cnt0 = ovs_count;
        wait_until(e + 200);
        check("post_reset_ticks", ovs_count - cnt0, 0);
        check("post_reset_pending", cfg_pending, 0);
        check("post_reset_err", cfg_err, 0);
        check("missing_ticks", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
